// File: rtl/alu_pkg.sv
// Shared ALU encodings: func codes, instruction field layout and the decode
// helpers used by the operand-fetch stage.
package alu_pkg;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SLL  = 4'b0011;
    localparam logic [3:0] FN_SLR  = 4'b0100;
    localparam logic [3:0] FN_SPEC = 4'b0111;
    localparam logic [3:0] FN_BLT  = 4'b1010;
    localparam logic [3:0] FN_BE   = 4'b1011;

    typedef struct packed {
        logic [3:0] func;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] spec_fun;
    } instr_t;

    function automatic logic writes_rd(input logic [3:0] f);
        return (f == FN_ADD) || (f == FN_SLL) || (f == FN_SLR) || (f == FN_SPEC);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] f);
        return (f == FN_ADD) || (f == FN_SLL) || (f == FN_SLR) ||
               (f == FN_BLT) || (f == FN_BE);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one write port,
// r0 hard-wired to zero.
module reg_file #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [2:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data2
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en && wr_addr != '0) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) mem_q <= '0;
        else          mem_q <= mem_d;
    end

    assign rd_data1 = (rd_addr1 == '0) ? '0 : mem_q[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : mem_q[rd_addr2];

endmodule

// File: rtl/decode_stage.sv
// Operand-fetch/decode stage ahead of the 8-bit ALU: register read, scoreboard
// hazard stall, write-back forwarding and a one-entry output register.
module decode_stage import alu_pkg::*; #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [3:0]        func,
    output logic [2:0]        spec_fun,
    output logic [2:0]        out_rd,
    output logic              out_wr_en
);

    instr_t ins;
    assign ins = in_instr;

    logic              wr_rd, use2, hazard, accept;
    logic [NREGS-1:0]  busy_q, busy_d, busy_eff;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, op1, op2;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
    logic [3:0]        func_q, func_d;
    logic [2:0]        spf_q, spf_d, rd_q, rd_d;
    logic              wr_en_q, wr_en_d;

    reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_reg_file (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr1 (ins.rs1),
        .rd_data1 (rf_rd1),
        .rd_addr2 (ins.rs2),
        .rd_data2 (rf_rd2)
    );

    always_comb begin
        wr_rd = writes_rd(ins.func);
        use2  = uses_rs2(ins.func);

        // With forwarding, a register being written back this cycle is already usable.
        busy_eff = busy_q;
        if (BYPASS && wb_en) busy_eff[wb_addr] = 1'b0;
        hazard = busy_eff[ins.rs1] | (use2 & busy_eff[ins.rs2]) | (wr_rd & busy_eff[ins.rd]);

        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;

        op1 = rf_rd1;
        op2 = rf_rd2;
        if (BYPASS && wb_en && wb_addr != '0) begin
            if (wb_addr == ins.rs1) op1 = wb_data;
            if (wb_addr == ins.rs2) op2 = wb_data;
        end

        // Set is applied after clear so a same-register collision stays busy.
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (accept && wr_rd && ins.rd != '0) busy_d[ins.rd] = 1'b1;

        out_valid_d = out_valid_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        func_d      = func_q;
        spf_d       = spf_q;
        rd_d        = rd_q;
        wr_en_d     = wr_en_q;
        if (out_ready) out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            reg1_d      = op1;
            reg2_d      = op2;
            func_d      = ins.func;
            spf_d       = ins.spec_fun;
            rd_d        = ins.rd;
            wr_en_d     = wr_rd;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            func_q      <= '0;
            spf_q       <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            func_q      <= func_d;
            spf_q       <= spf_d;
            rd_q        <= rd_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign out_valid = out_valid_q;
    assign reg1      = reg1_q;
    assign reg2      = reg2_q;
    assign func      = func_q;
    assign spec_fun  = spf_q;
    assign out_rd    = rd_q;
    assign out_wr_en = wr_en_q;

endmodule
